// File: rtl/sm_hex_pkg.sv
`default_nettype none
// ==========================================================================
// sm_hex_pkg : seven-segment codes, segment bit order, counter width helper
// rev 1.0
// ==========================================================================
package sm_hex_pkg;

  // Bit positions inside the {g,f,e,d,c,b,a} segment vector
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high segment codes for hex digits 0..F
  localparam logic [6:0] HEX_0 = 7'h3F;
  localparam logic [6:0] HEX_1 = 7'h06;
  localparam logic [6:0] HEX_2 = 7'h5B;
  localparam logic [6:0] HEX_3 = 7'h4F;
  localparam logic [6:0] HEX_4 = 7'h66;
  localparam logic [6:0] HEX_5 = 7'h6D;
  localparam logic [6:0] HEX_6 = 7'h7D;
  localparam logic [6:0] HEX_7 = 7'h07;
  localparam logic [6:0] HEX_8 = 7'h7F;
  localparam logic [6:0] HEX_9 = 7'h6F;
  localparam logic [6:0] HEX_A = 7'h77;
  localparam logic [6:0] HEX_B = 7'h7C;
  localparam logic [6:0] HEX_C = 7'h39;
  localparam logic [6:0] HEX_D = 7'h5E;
  localparam logic [6:0] HEX_E = 7'h79;
  localparam logic [6:0] HEX_F = 7'h71;

  // Width of a counter spanning 0..n-1; never below one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_hex_digit_decoder.sv
`default_nettype none
// ==========================================================================
// sm_hex_digit_decoder : combinational nibble -> active-high 7-segment code
// rev 1.0
// ==========================================================================
module sm_hex_digit_decoder
  import sm_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  always_comb begin
    code = HEX_0;
    case (nibble)
      4'h0: code = HEX_0;
      4'h1: code = HEX_1;
      4'h2: code = HEX_2;
      4'h3: code = HEX_3;
      4'h4: code = HEX_4;
      4'h5: code = HEX_5;
      4'h6: code = HEX_6;
      4'h7: code = HEX_7;
      4'h8: code = HEX_8;
      4'h9: code = HEX_9;
      4'hA: code = HEX_A;
      4'hB: code = HEX_B;
      4'hC: code = HEX_C;
      4'hD: code = HEX_D;
      4'hE: code = HEX_E;
      4'hF: code = HEX_F;
      default: code = HEX_0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sm_hex_display_scan.sv
`default_nettype none
// ==========================================================================
// sm_hex_display_scan : multiplexed N-digit 7-seg scanner with frame shadow
// latch; optional dimming via SM_HEX_DISPLAY_DIM_EN.  rev 1.0
// ==========================================================================
module sm_hex_display_scan
  import sm_hex_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  blank_lz,
`ifdef SM_HEX_DISPLAY_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_start
);

  localparam int PRE_W = cnt_width(REFRESH_DIV);
  localparam int IDX_W = cnt_width(DIGITS);

  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DOT_OFF = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRE_W-1:0]    prescaler;
  logic [IDX_W-1:0]    index;
  logic                pending;
  logic [4*DIGITS-1:0] sh_number;
  logic [DIGITS-1:0]   sh_dots;
  logic                sh_blank_lz;

  logic                tick;
  logic                wrap;
  logic                load;
  logic                in_window;
  logic [3:0]          nibble;
  logic [6:0]          code;
  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   onehot;
  logic                nz_acc;
  logic [6:0]          seg_next;
  logic                dot_next;
  logic [DIGITS-1:0]   an_next;

  assign tick = (prescaler == PRE_W'(REFRESH_DIV - 1));
  assign wrap = tick && (index == IDX_W'(DIGITS - 1));
  // The first enabled cycle after reset latches the shadow without advancing,
  // so that frame always starts at index 0 / prescaler 0 like every later one.
  assign load = enable && (pending || wrap);

`ifdef SM_HEX_DISPLAY_DIM_EN
  localparam int SPAN = REFRESH_DIV - GUARD;
  logic [3:0] sh_bright;
  int         on_end;
  assign on_end    = GUARD + (((int'(sh_bright) + 1) * SPAN) >> 4);
  assign in_window = (int'(prescaler) >= GUARD) && (int'(prescaler) < on_end);
`else
  assign in_window = (int'(prescaler) >= GUARD);
`endif

  assign nibble = sh_number[int'(index)*4 +: 4];

  sm_hex_digit_decoder u_decoder (
    .nibble (nibble),
    .code   (code)
  );

  // A digit is blank when it and every more-significant nibble are zero
  always_comb begin
    nz_acc     = 1'b0;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_acc        = nz_acc | (|sh_number[4*i +: 4]);
      blank_mask[i] = sh_blank_lz && (i != 0) && !nz_acc;
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      onehot[i] = (int'(index) == i);
    end
  end

  always_comb begin
    seg_next = SEG_OFF;
    dot_next = DOT_OFF;
    an_next  = AN_OFF;
    if (enable && in_window) begin
      an_next  = AN_ACTIVE_LOW ? ~onehot : onehot;
      dot_next = SEG_ACTIVE_LOW ? ~sh_dots[index] : sh_dots[index];
      if (!blank_mask[index]) begin
        seg_next = SEG_ACTIVE_LOW ? ~code : code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler      <= '0;
      index          <= '0;
      pending        <= 1'b1;
      sh_number      <= '0;
      sh_dots        <= '0;
      sh_blank_lz    <= 1'b0;
`ifdef SM_HEX_DISPLAY_DIM_EN
      sh_bright      <= '0;
`endif
      seven_segments <= SEG_OFF;
      dot            <= DOT_OFF;
      anodes         <= AN_OFF;
      frame_start    <= 1'b0;
    end else begin
      frame_start    <= load;
      seven_segments <= seg_next;
      dot            <= dot_next;
      anodes         <= an_next;
      if (enable) begin
        if (pending) begin
          pending <= 1'b0;
        end else begin
          prescaler <= tick ? '0 : prescaler + 1'b1;
          if (tick) begin
            index <= wrap ? '0 : index + 1'b1;
          end
        end
        if (load) begin
          sh_number   <= number;
          sh_dots     <= dots;
          sh_blank_lz <= blank_lz;
`ifdef SM_HEX_DISPLAY_DIM_EN
          sh_bright   <= brightness;
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_hex_display_scan.sv
`default_nettype none
// ==========================================================================
// tb_sm_hex_display_scan : scoreboard bench, DIGITS=4 REFRESH_DIV=4 GUARD=1,
// active-low segments and anodes.  rev 1.0
// ==========================================================================
module tb_sm_hex_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] number;
  logic [3:0]  dots;
  logic        blank_lz;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [3:0]  anodes;
  logic        frame_start;
`ifdef SM_HEX_DISPLAY_DIM_EN
  logic [3:0]  brightness = 4'hF;
`endif

  always #5 clk = ~clk;

  sm_hex_display_scan #(
    .DIGITS         (4),
    .REFRESH_DIV    (4),
    .GUARD          (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .number         (number),
    .dots           (dots),
    .blank_lz       (blank_lz),
`ifdef SM_HEX_DISPLAY_DIM_EN
    .brightness     (brightness),
`endif
    .seven_segments (seven_segments),
    .dot            (dot),
    .anodes         (anodes),
    .frame_start    (frame_start)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dt;
    logic       fs;
  } exp_t;

  typedef struct packed {
    logic [15:0]     number;
    logic [3:0]      dots;
    logic            blz;
    logic [3:0][6:0] seg;   // expected active-low code per digit
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  vec_t v2222;
  int   checks = 0;
  int   errors = 0;

  // Expected output for cycle k (0..15) of a frame: 4 slots of 4 clocks,
  // first clock of each slot is the all-off guard.
  function automatic exp_t frame_exp(vec_t v, int k);
    exp_t e;
    int   d;
    int   p;
    d    = k / 4;
    p    = k % 4;
    e.fs = (k == 15);
    if (p == 0) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dt  = 1'b1;
    end else begin
      e.an  = ~(4'b0001 << d);
      e.seg = v.seg[d];
      e.dt  = ~v.dots[d];
    end
    return e;
  endfunction

  task automatic push_frame(vec_t v, int lo, int hi);
    for (int k = lo; k <= hi; k++) sb.push_back(frame_exp(v, k));
  endtask

  task automatic push_off(int n, logic fs);
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dt  = 1'b1;
    e.fs  = fs;
    for (int k = 0; k < n; k++) sb.push_back(e);
  endtask

  task automatic check_n(string tag, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty at sample %0d", tag, k);
      end else begin
        e = sb.pop_front();
        if ({anodes, seven_segments, dot, frame_start} !== {e.an, e.seg, e.dt, e.fs}) begin
          errors++;
          $display("FAIL %s[%0d]: got an=%h seg=%h dot=%b fs=%b, want an=%h seg=%h dot=%b fs=%b",
                   tag, k, anodes, seven_segments, dot, frame_start, e.an, e.seg, e.dt, e.fs);
        end
      end
    end
  endtask

  // Wait for a fresh frame_start, bounded
  task automatic sync_frame();
    int t;
    t = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL sync_frame: no frame_start within 100 cycles, got fs=%b", frame_start);
    end
  endtask

  task automatic drive(vec_t v);
    number   = v.number;
    dots     = v.dots;
    blank_lz = v.blz;
  endtask

  initial begin
    vecs[0] = '{16'h12A0, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h40}};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{16'h1111, 4'b0100, 1'b0, {7'h79, 7'h79, 7'h79, 7'h79}};
    vecs[4] = '{16'h00F0, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40}};
    vecs[5] = '{16'hDCB9, 4'b1111, 1'b1, {7'h21, 7'h46, 7'h03, 7'h10}};
    vecs[6] = '{16'h8E64, 4'b0001, 1'b0, {7'h00, 7'h06, 7'h02, 7'h19}};
    vecs[7] = '{16'h3007, 4'b0000, 1'b1, {7'h30, 7'h40, 7'h40, 7'h78}};
    v2222   = '{16'h2222, 4'b0100, 1'b0, {7'h24, 7'h24, 7'h24, 7'h24}};

    rst      = 1'b1;
    enable   = 1'b1;
    number   = 16'h0;
    dots     = 4'h0;
    blank_lz = 1'b0;

    // Reset state, then the first frame right after release
    push_off(3, 1'b0);
    check_n("reset", 3);
    drive(vecs[0]);
    rst = 1'b0;
    push_off(1, 1'b1);
    push_frame(vecs[0], 0, 15);
    check_n("first_frame", 17);

    // Table-driven frames
    for (int i = 1; i < 8; i++) begin
      drive(vecs[i]);
      push_frame(vecs[i], 0, 15);
      sync_frame();
      check_n("vector", 16);
    end

    // Input change during digit 2 slot is invisible until the next frame
    drive(vecs[3]);
    push_frame(vecs[3], 0, 9);
    sync_frame();
    check_n("midframe_old", 10);
    number = 16'h2222;
    push_frame(vecs[3], 10, 15);
    check_n("midframe_old", 6);
    push_frame(v2222, 0, 15);
    check_n("midframe_new", 16);

    // Enable pause mid-slot: outputs off, slot then completes
    drive(vecs[0]);
    push_frame(vecs[0], 0, 6);
    push_off(10, 1'b0);
    push_frame(vecs[0], 7, 15);
    sync_frame();
    check_n("pause_pre", 7);
    enable = 1'b0;
    check_n("pause_hold", 10);
    enable = 1'b1;
    check_n("pause_resume", 9);

    // Reset during digit 3 slot
    drive(vecs[5]);
    push_frame(vecs[5], 0, 13);
    sync_frame();
    check_n("pre_reset", 14);
    rst = 1'b1;
    push_off(2, 1'b0);
    check_n("reset_mid", 2);
    rst = 1'b0;
    push_off(1, 1'b1);
    push_frame(vecs[5], 0, 15);
    check_n("post_reset", 17);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm_hex_display_scan.md
Name: sm_hex_display_scan

Overview:
- Parametrised multiplexed seven-segment driver: N-digit scan, internal refresh prescaler, frame-synchronous shadow latch, per-digit dots, leading-zero suppression, configurable anode/segment polarity.
- Sits in board tops between core debug data (register value) and the seg/dp/an pins.
- Runs on the board clock directly; no external hex clock divider required.

Parameters:
- DIGITS, 8, number of digits scanned (1..16).
- REFRESH_DIV, 50000, clocks per digit slot (>= GUARD+2).
- GUARD, 64, clocks at start of each slot with all anodes inactive (anti-ghosting).
- SEG_ACTIVE_LOW, 1, segment/dot pins driven low = lit.
- AN_ACTIVE_LOW, 1, anode pins driven low = selected.

Ports:
- clk  in  1  board clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  scan enable; low freezes counters, anodes inactive
- number  in  4*DIGITS  hex value, digit 0 = bits [3:0]
- dots  in  DIGITS  per-digit decimal point request
- blank_lz  in  1  suppress leading zeros
- seven_segments  out  7  {g,f,e,d,c,b,a}
- dot  out  1  decimal point
- anodes  out  DIGITS  digit select, bit i = digit i
- frame_start  out  1  one-cycle pulse when digit 0 slot begins (shadow latched)

Behaviour:
- Reset (and the cycle after it): prescaler=0, index=0, shadow number/dots=0; anodes all inactive, segments and dot unlit (polarity-correct), frame_start=0.
- Prescaler counts 0..REFRESH_DIV-1, wraps; tick at REFRESH_DIV-1. On tick, index increments, wrapping DIGITS-1 -> 0.
- When index wraps to 0 (and on the first slot after reset), number/dots/blank_lz copy into shadow registers in the same cycle; frame_start is asserted for exactly that cycle. Input changes mid-frame are invisible until the next frame.
- All outputs are registered and reflect the current index/prescaler with 1-cycle latency.
- Anode for index is active when prescaler >= GUARD; during prescaler < GUARD all anodes are inactive and segments are unlit.
- Decode (active-high form, 0..F): 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; inverted when SEG_ACTIVE_LOW.
- Leading-zero suppression (shadow blank_lz=1): digit i>0 is blank if shadow nibbles i..DIGITS-1 are all 0. Digit 0 is never blanked. A blanked digit keeps its anode active, segments unlit, and its dot still honoured.
- enable=0: prescaler/index hold, anodes inactive, frame_start=0. Resume continues from the held state.
- Reset mid-frame: immediate return to the reset state; no partial frame is completed.
- DIGITS=1: every tick is a frame boundary; frame_start is asserted each slot.

Optional Feature:
- Macro SM_HEX_DISPLAY_DIM_EN.
- Defined: adds input brightness [3:0]. Anode is active only while GUARD <= prescaler < GUARD + ((brightness+1)*(REFRESH_DIV-GUARD))>>4; brightness=15 gives full duty. The shadow latch covers brightness.
- Undefined: no port; full duty after GUARD.

Decomposition:
- Package sm_hex_pkg: seven-segment code constants 0..F, segment bit-order constants, function computing the prescaler counter width ($clog2(REFRESH_DIV)).
- One sub-module: sm_hex_digit_decoder, a combinational nibble -> active-high 7-bit code decoder. Polarity is applied in the parent's output registers.

Test Plan (DIGITS=4, REFRESH_DIV=4, GUARD=1, active-low):
- Reset then number=16'h12A0, dots=0, blank_lz=0, enable=1 -> each frame, anodes step 1110,1101,1011,0111 per 4-clk slot; segs 0x40 (0), 0x08 (A), 0x24 (2), 0x79 (1); guard cycle shows anodes=1111, segs=0x7F.
- number=16'h0005, blank_lz=1 -> digit0 segs 0x12; digits 1-3 anodes active, segs 0x7F. Same with number=16'h0000 -> digit0 shows 0x40.
- Change number from 16'h1111 to 16'h2222 during digit 2 slot -> digits 2,3 still show 1 (0x79); 2 (0x24) appears only after frame_start.
- dots=4'b0100 -> dot=0 only in digit 2 slot, excluding the guard cycle; dot=1 elsewhere.
- enable low for 10 clks mid-slot -> anodes=1111, index/prescaler unchanged; after re-enable the slot completes its remaining cycles.
- Assert rst during digit 3 -> next cycle anodes=1111, segs=0x7F, dot=1; frame_start pulses at the first slot after release.
